memoria_dados_ctrl: RTL

MEMORIA_DADOS_CTRL -- requirements
Module: memoria_dados_ctrl

---
 rtl/mem_pkg.sv | 25 ++
 rtl/memoria_dados_ctrl_if.sv | 25 ++
 rtl/mem_array_sp.sv | 36 +++
 rtl/memoria_dados_ctrl.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types for the data-memory controller: FSM state encoding,
// operation codes and the wait-counter width.
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

   // Bit 0 = read request, bit 1 = write request; both set is a conflict.
   typedef logic [1:0] op_t;

   localparam op_t OP_RD       = 2'b01;
   localparam op_t OP_WR       = 2'b10;
   localparam op_t OP_CONFLICT = 2'b11;

   localparam int CNT_W    = 4;
   localparam int WAIT_MAX = 15;

   function automatic op_t encode_op(input logic rd, input logic wr);
      return {wr, rd};
   endfunction

endpackage

// File: rtl/memoria_dados_ctrl_if.sv
// Request/response bus between the control unit (master) and the
// data-memory controller (slave).
interface memoria_dados_ctrl_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
);
   logic              mReadFlag;
   logic              mWriteFlag;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic              ready;
   logic              busy;
   logic              err;

   modport master (
      output mReadFlag, mWriteFlag, addr, wdata,
      input  rdata, ready, busy, err
   );

   modport slave (
      input  mReadFlag, mWriteFlag, addr, wdata,
      output rdata, ready, busy, err
   );
endinterface

// File: rtl/mem_array_sp.sv
// Single-port storage array: synchronous write, registered read data that
// holds until the next read. Contents are deliberately not reset.
module mem_array_sp #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic              re,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem_r [2**ADDR_W];
   logic [DATA_W-1:0] rdata_r;

   // Storage write port.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[addr] <= wdata;
      end
   end

   // Read data register, cleared by reset only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_r <= '0;
      end else if (re) begin
         rdata_r <= mem_r[addr];
      end
   end

   assign rdata = rdata_r;

endmodule

// File: rtl/memoria_dados_ctrl.sv
// Data-memory access controller: IDLE/WAIT/DONE sequencer with programmable
// wait states. Optional write protection above PROT_BASE via WRITE_PROTECT_EN.
module memoria_dados_ctrl
   import mem_pkg::*;
#(
   parameter int ADDR_W      = 8,
   parameter int DATA_W      = 16,
   parameter int WAIT_CYCLES = 1,
   parameter int PROT_BASE   = 32'h0000_00F0
) (
   input logic                 clk,
   input logic                 rst,
   memoria_dados_ctrl_if.slave bus
);

   if (WAIT_CYCLES < 0 || WAIT_CYCLES > WAIT_MAX ||
       PROT_BASE < 0 || PROT_BASE >= 2 ** ADDR_W) begin : g_param_check
      $error("memoria_dados_ctrl: parameter out of range");
   end

`ifdef WRITE_PROTECT_EN
   localparam logic [ADDR_W-1:0] PROT_BASE_A = ADDR_W'(PROT_BASE);
`endif

   state_t            state_r;
   state_t            state_s;
   logic [CNT_W-1:0]  cnt_r;
   logic [CNT_W-1:0]  cnt_s;
   op_t               op_r;
   op_t               cur_op_s;
   logic [ADDR_W-1:0] addr_r;
   logic [ADDR_W-1:0] cur_addr_s;
   logic [DATA_W-1:0] wdata_r;
   logic [DATA_W-1:0] cur_wdata_s;
   logic [DATA_W-1:0] rdata_s;
   logic              req_s;
   logic              done_s;
   logic              prot_s;
   logic              we_s;
   logic              re_s;
   logic              err_s;
   logic              ready_r;
   logic              err_r;
   logic              busy_r;

   assign req_s = bus.mReadFlag | bus.mWriteFlag;

   // With zero wait states the access happens on the sampling edge itself,
   // so the bus is used directly while IDLE and the captured copy afterwards.
   always_comb begin
      if (state_r == IDLE) begin
         cur_op_s    = encode_op(bus.mReadFlag, bus.mWriteFlag);
         cur_addr_s  = bus.addr;
         cur_wdata_s = bus.wdata;
      end else begin
         cur_op_s    = op_r;
         cur_addr_s  = addr_r;
         cur_wdata_s = wdata_r;
      end
   end

   // Next-state and wait-counter logic.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      case (state_r)
         IDLE: begin
            if (req_s) begin
               cnt_s = CNT_W'(WAIT_CYCLES);
               if (WAIT_CYCLES > 0) begin
                  state_s = WAIT;
               end else begin
                  state_s = DONE;
               end
            end else begin
               state_s = IDLE;
            end
         end
         WAIT: begin
            cnt_s = cnt_r - CNT_W'(1);
            if (cnt_r == CNT_W'(1)) begin
               state_s = DONE;
            end else begin
               state_s = WAIT;
            end
         end
         DONE: begin
            state_s = IDLE;
            cnt_s   = '0;
         end
         default: begin
            state_s = IDLE;
            cnt_s   = '0;
         end
      endcase
   end

   // Array strobes fire on the edge entering DONE; reset blocks any access.
   always_comb begin
      done_s = (state_s == DONE) && !rst;
`ifdef WRITE_PROTECT_EN
      prot_s = (cur_addr_s >= PROT_BASE_A);
`else
      prot_s = 1'b0;
`endif
      we_s  = done_s && (cur_op_s == OP_WR) && !prot_s;
      re_s  = done_s && (cur_op_s == OP_RD);
      err_s = done_s && ((cur_op_s == OP_CONFLICT) || ((cur_op_s == OP_WR) && prot_s));
   end

   // State, counter, request capture and registered status outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
         cnt_r   <= '0;
         op_r    <= '0;
         addr_r  <= '0;
         wdata_r <= '0;
         ready_r <= 1'b0;
         err_r   <= 1'b0;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         ready_r <= done_s;
         err_r   <= err_s;
         busy_r  <= (state_s != IDLE);
         if (state_r == IDLE && req_s) begin
            op_r    <= cur_op_s;
            addr_r  <= cur_addr_s;
            wdata_r <= cur_wdata_s;
         end
      end
   end

   mem_array_sp #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_array (
      .clk   (clk),
      .rst   (rst),
      .we    (we_s),
      .re    (re_s),
      .addr  (cur_addr_s),
      .wdata (cur_wdata_s),
      .rdata (rdata_s)
   );

   assign bus.rdata = rdata_s;
   assign bus.ready = ready_r;
   assign bus.err   = err_r;
   assign bus.busy  = busy_r;

endmodule
